// File: rtl/b06_pkg.sv
// Shared types for the b06 request front-end: FSM states and CC_MUX select codes.
package b06_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CCM_ANY = 2'd0,
    CCM_R1  = 2'd1,
    CCM_R2  = 2'd2,
    CCM_R3  = 2'd3
  } ccm_t;

endpackage

// File: rtl/b06_sync.sv
// Multi-flop synchroniser for the raw request, cleared synchronously with the block reset.
module b06_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock) begin
    if (clr) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/b06_req_front.sv
// Request front-end for the b06 handler: sync + edge detect, request FSM,
// data latch and reference compare (EQL), saturating timeout counter (CONT_EQL).
module b06_req_front
  import b06_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       CNT_W       = 4,
  parameter int unsigned       CNT_TERM    = 9,
  parameter logic [DATA_W-1:0] REF1        = DATA_W'(8'h0F),
  parameter logic [DATA_W-1:0] REF2        = DATA_W'(8'hF0),
  parameter logic [DATA_W-1:0] REF3        = DATA_W'(8'hFF)
) (
  input  logic              clock,
  input  logic              RESET_G,
  input  logic              REQ_IN,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [1:0]        CC_MUX,
  input  logic              ENABLE_COUNT,
  input  logic              ACKOUT,
  output logic              EQL,
  output logic              CONT_EQL,
  output logic              ERR_OVR
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CNT_TERM);

  logic              req_s;
  logic              req_d;
  logic              rise;
  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_nxt;
  logic              pend_nxt;
  logic              match;
  logic [CNT_W-1:0]  cnt;

  b06_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .clr   (RESET_G),
    .d     (REQ_IN),
    .q     (req_s)
  );

  assign rise = req_s & ~req_d;

  // Data is captured only when a request is accepted from IDLE.
  assign data_nxt = (state == IDLE && rise) ? DATA_IN : data_q;
  assign pend_nxt = (state == IDLE && rise) || (state == PEND && !ACKOUT);

  // Compare against the value DATA_Q will hold after this edge.
  always_comb begin
    match = 1'b1;
    case (ccm_t'(CC_MUX))
      CCM_ANY: match = 1'b1;
      CCM_R1:  match = (data_nxt == REF1);
      CCM_R2:  match = (data_nxt == REF2);
      CCM_R3:  match = (data_nxt == REF3);
      default: match = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (RESET_G) begin
      req_d   <= 1'b0;
      state   <= IDLE;
      data_q  <= '0;
      EQL     <= 1'b0;
      ERR_OVR <= 1'b0;
      cnt     <= '0;
    end else begin
      req_d  <= req_s;
      data_q <= data_nxt;
      EQL    <= pend_nxt & match;

      case (state)
        IDLE:     if (rise) state <= PEND;
        PEND: begin
          if (ACKOUT)    state   <= WAIT_LOW;
          else if (rise) ERR_OVR <= 1'b1;
        end
        WAIT_LOW: if (!req_s) state <= IDLE;
        default:  state <= IDLE;
      endcase

      // Saturating timeout counter; never wraps past the terminal count.
      if (!ENABLE_COUNT)    cnt <= '0;
      else if (cnt != TERM) cnt <= cnt + CNT_W'(1);
    end
  end

  assign CONT_EQL = (cnt == TERM);

endmodule

// File: tb/tb_b06_req_front.sv
// Directed, table-driven bench for b06_req_front with hand-computed expectations.
module tb_b06_req_front;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] ccm = 2'b00;
  logic       en = 1'b0;
  logic       ack = 1'b0;
  logic       eql;
  logic       cont;
  logic       err;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  b06_req_front dut (
    .clock        (clock),
    .RESET_G      (rst),
    .REQ_IN       (req),
    .DATA_IN      (data),
    .CC_MUX       (ccm),
    .ENABLE_COUNT (en),
    .ACKOUT       (ack),
    .EQL          (eql),
    .CONT_EQL     (cont),
    .ERR_OVR      (err)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       req;
    logic [7:0] data;
    logic [1:0] ccm;
    logic       en;
    logic       ack;
    int         edges;
    logic       eql;
    logic       cont;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic q, logic [7:0] d, logic [1:0] c,
                              logic e, logic a, int k, logic xe, logic xc, logic xr);
    vec_t v;
    v.name = n; v.rst = r; v.req = q; v.data = d; v.ccm = c; v.en = e; v.ack = a;
    v.edges = k; v.eql = xe; v.cont = xc; v.err = xr;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string n, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", n, act, exp);
  endtask

  task automatic chk_all(input string n, input logic xe, input logic xc, input logic xr);
    chk({n, ".eql"}, eql, xe);
    chk({n, ".cont_eql"}, cont, xc);
    chk({n, ".err_ovr"}, err, xr);
  endtask

  initial begin
    // With two sync stages, a request driven between edges is accepted on the 3rd edge.
    //              name          rst req data   ccm  en ack edges eql cont err
    vecs.push_back(mk("reset",      1, 0, 8'h00, 2'd0, 0, 0, 2,  0, 0, 0));
    vecs.push_back(mk("idle10",     0, 0, 8'h00, 2'd0, 0, 0, 10, 0, 0, 0));
    vecs.push_back(mk("ack_idle",   0, 0, 8'h00, 2'd0, 0, 1, 2,  0, 0, 0));
    vecs.push_back(mk("r1_sync",    0, 1, 8'h0F, 2'd1, 0, 0, 2,  0, 0, 0));
    vecs.push_back(mk("r1_hit",     0, 1, 8'h0F, 2'd1, 0, 0, 1,  1, 0, 0));
    vecs.push_back(mk("r1_ack",     0, 1, 8'h0F, 2'd1, 0, 1, 1,  0, 0, 0));
    vecs.push_back(mk("wait_low",   0, 1, 8'h0F, 2'd1, 0, 0, 3,  0, 0, 0));
    vecs.push_back(mk("to_idle",    0, 0, 8'h0F, 2'd1, 0, 0, 3,  0, 0, 0));
    vecs.push_back(mk("r2_miss",    0, 1, 8'h0F, 2'd2, 0, 0, 3,  0, 0, 0));
    vecs.push_back(mk("ccm_any",    0, 1, 8'h0F, 2'd0, 0, 0, 1,  1, 0, 0));
    vecs.push_back(mk("r3_miss",    0, 1, 8'hFF, 2'd3, 0, 0, 1,  0, 0, 0));
    vecs.push_back(mk("r1_held",    0, 1, 8'hFF, 2'd1, 0, 0, 1,  1, 0, 0));
    vecs.push_back(mk("req_low",    0, 0, 8'hF0, 2'd1, 0, 0, 2,  1, 0, 0));
    vecs.push_back(mk("ovr_rise",   0, 1, 8'hF0, 2'd1, 0, 0, 3,  1, 0, 1));
    vecs.push_back(mk("ovr_r2",     0, 1, 8'hF0, 2'd2, 0, 0, 1,  0, 0, 1));
    vecs.push_back(mk("ovr_ack",    0, 1, 8'hF0, 2'd1, 0, 1, 1,  0, 0, 1));
    vecs.push_back(mk("ovr_sticky", 0, 0, 8'hF0, 2'd1, 0, 0, 3,  0, 0, 1));
    vecs.push_back(mk("r2_hit",     0, 1, 8'hF0, 2'd2, 0, 0, 3,  1, 0, 1));
    vecs.push_back(mk("cnt5",       0, 1, 8'h00, 2'd2, 1, 0, 5,  1, 0, 1));
    vecs.push_back(mk("mid_reset",  1, 1, 8'h00, 2'd0, 0, 0, 1,  0, 0, 0));
    vecs.push_back(mk("refill",     0, 1, 8'h00, 2'd0, 0, 0, 2,  0, 0, 0));
    vecs.push_back(mk("re_rise",    0, 1, 8'h00, 2'd0, 0, 0, 1,  1, 0, 0));
    vecs.push_back(mk("retire",     0, 1, 8'h00, 2'd0, 0, 1, 1,  0, 0, 0));
    vecs.push_back(mk("settle",     0, 0, 8'h00, 2'd0, 0, 0, 3,  0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; req = vecs[i].req; data = vecs[i].data;
      ccm = vecs[i].ccm; en = vecs[i].en; ack = vecs[i].ack;
      step(vecs[i].edges);
      chk_all(vecs[i].name, vecs[i].eql, vecs[i].cont, vecs[i].err);
    end

    // Counter: reaches terminal count after 9 enabled edges, saturates, clears on disable.
    en = 1'b1;
    step(8);
    chk("cnt_8", cont, 1'b0);
    step(1);
    chk("cnt_9", cont, 1'b1);
    step(10);
    chk("cnt_sat", cont, 1'b1);
    en = 1'b0;
    step(1);
    chk("cnt_clr", cont, 1'b0);
    en = 1'b1;
    step(9);
    chk("cnt_again", cont, 1'b1);
    en = 1'b0;
    step(1);
    chk("cnt_clr2", cont, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
